// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
// Holds the FSM state enum, opcode/ALUOp/ALUSrcB constants and the datapath control bundle.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        ALU_WB,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        BRANCH,
        TRAP
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unsupported traps.
    function automatic state_e dispatch(input logic [6:0] op);
        case (op)
            OP_RTYPE:           return EXEC_R;
            OP_LOAD, OP_STORE:  return MEM_ADDR;
            OP_BRANCH:          return BRANCH;
            default:            return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: counts instrDone pulses, wrapping at 2^WIDTH.
module retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instrDone,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (instrDone) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath (fetch/decode/execute/memory/writeback).
// Define MULTICYCLE_CTRL_PERF_EN to add the retiredCount port and its counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
`ifdef MULTICYCLE_CTRL_PERF_EN
#(
    parameter int COUNT_WIDTH = 32
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       regWrite,
    output logic       memToReg,
    output logic       instrDone,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [COUNT_WIDTH-1:0] retiredCount,
`endif
    output logic       illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:     if (enable && memReady) state_d = DECODE;
            DECODE:    state_d = dispatch(opcode);
            EXEC_R:    state_d = ALU_WB;
            ALU_WB:    state_d = FETCH;
            MEM_ADDR:  state_d = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (memReady) state_d = MEM_WB;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: if (memReady) state_d = FETCH;
            BRANCH:    state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = FETCH;
        endcase
    end

    assign illegal_d = illegal_q | ((state_q == DECODE) && (state_d == TRAP));

    // NOTE: the all-zero default up front keeps this block free of inferred latches.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            FETCH: begin
                if (enable) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.ir_write  = memReady;
                    ctrl.pc_write  = memReady;
                end
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = memReady;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = zero;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign ALUOp     = ctrl.alu_op;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign IorD      = ctrl.iord;
    assign memRead   = ctrl.mem_read;
    assign memWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign PCWrite   = ctrl.pc_write;
    assign PCSrc     = ctrl.pc_src;
    assign regWrite  = ctrl.reg_write;
    assign memToReg  = ctrl.mem_to_reg;
    assign instrDone = ctrl.instr_done;
    assign illegal   = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    retire_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_retire_counter (
        .clock    (clock),
        .reset    (reset),
        .instrDone(ctrl.instr_done),
        .count_o  (retiredCount)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model with random waits.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] opcode;
  logic       zero;
  logic       memReady;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, memRead, memWrite, IRWrite, PCWrite, PCSrc;
  logic       regWrite, memToReg, instrDone, illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [3:0] retiredCount;
  logic [3:0] exp_retired;
`endif

  int total = 0;
  int bad   = 0;

`ifdef MULTICYCLE_CTRL_PERF_EN
  multicycle_control #(.COUNT_WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .opcode      (opcode),
    .zero        (zero),
    .memReady    (memReady),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .IorD        (IorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .regWrite    (regWrite),
    .memToReg    (memToReg),
    .instrDone   (instrDone),
    .retiredCount(retiredCount),
    .illegal     (illegal)
  );
`else
  multicycle_control dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .opcode      (opcode),
    .zero        (zero),
    .memReady    (memReady),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .IorD        (IorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCSrc       (PCSrc),
    .regWrite    (regWrite),
    .memToReg    (memToReg),
    .instrDone   (instrDone),
    .illegal     (illegal)
  );
`endif

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction kinds: 0 R-type, 1 load, 2 store, 3 beq.
  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      0:       return 7'b0110011;
      1:       return 7'b0000011;
      2:       return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  function automatic int cpi_of(input int kind);
    case (kind)
      0:       return 4;
      1:       return 5;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  // Runs one instruction: fw fetch wait cycles, mw memory wait cycles, zmode<0 = random zero.
  task automatic run_instr(input int kind, input int fw, input int mw, input int zmode);
    bit mem;
    bit done;
    int last;
    int k;
    mem  = (kind == 1) || (kind == 2);
    last = fw + cpi_of(kind) - 1 + (mem ? mw : 0);
    done = 1'b0;
    k    = 0;
    while (!done && k <= last + 6) begin
      enable = (k <= fw) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k < fw)                                     memReady = 1'b0;
      else if (k == fw)                               memReady = 1'b1;
      else if (mem && k >= fw + 3 && k < fw + 3 + mw) memReady = 1'b0;
      else if (mem && k == fw + 3 + mw)               memReady = 1'b1;
      else                                            memReady = 1'($urandom_range(0, 1));
      opcode = (k <= fw) ? 7'($urandom) : op_of(kind);
      zero   = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clock);
      if (k <= fw) begin
        check("fetch_memRead", 32'(memRead), 32'd1);
        check("fetch_IRWrite", 32'(IRWrite), 32'(k == fw));
      end
      if (k == fw + 1) check("decode_srcB", 32'(ALUSrcB), 32'd2);
      if (k == fw + 2 && kind == 0) check("exec_ALUOp", 32'(ALUOp), 32'd2);
      if (k == fw + 2 && mem) check("addr_ALUOp", 32'(ALUOp), 32'd0);
      if (instrDone) begin
        done = 1'b1;
        check("done_cycle", 32'(k), 32'(last));
        check("done_regWrite", 32'(regWrite), 32'(kind <= 1));
        check("done_memToReg", 32'(memToReg), 32'(kind == 1));
        check("done_memWrite", 32'(memWrite), 32'(kind == 2));
        check("done_PCWrite", 32'(PCWrite), 32'(kind == 3 && zero));
        if (kind == 3) begin
          check("beq_ALUOp", 32'(ALUOp), 32'd1);
          check("beq_PCSrc", 32'(PCSrc), 32'd1);
        end
      end
      @(posedge clock);
      #1;
      k++;
    end
    check("instr_completed", 32'(done), 32'd1);
`ifdef MULTICYCLE_CTRL_PERF_EN
    if (done) exp_retired = exp_retired + 4'd1;
    check("retired", 32'(retiredCount), 32'(exp_retired));
`endif
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    opcode   = 7'd0;
    zero     = 1'b0;
    memReady = 1'b0;
`ifdef MULTICYCLE_CTRL_PERF_EN
    exp_retired = 4'd0;
`endif
    #12;
    check("rst_memRead", 32'(memRead), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_instrDone", 32'(instrDone), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 17 back-to-back zero-wait stores (counter wraps to 1 at width 4)
    for (int i = 0; i < 17; i++) run_instr(2, 0, 0, -1);

    // Directed: R-type, load with 3 waits (8 cycles), beq taken and not taken
    run_instr(0, 0, 0, -1);
    run_instr(1, 0, 3, -1);
    run_instr(3, 0, 0, 1);
    run_instr(3, 0, 0, 0);

    // Idle with enable low: no strobes, FSM stays in FETCH
    for (int i = 0; i < 5; i++) begin
      enable   = 1'b0;
      memReady = 1'b1;
      opcode   = 7'($urandom);
      @(negedge clock);
      check("idle_memRead", 32'(memRead), 32'd0);
      check("idle_PCWrite", 32'(PCWrite), 32'd0);
      check("idle_srcB", 32'(ALUSrcB), 32'd0);
      @(posedge clock);
      #1;
    end
    run_instr(0, 1, 0, -1);

    // Random instruction stream
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1);
    end

    // Reset in the middle of a stalled MEM_READ
    enable   = 1'b1;
    memReady = 1'b1;
    opcode   = 7'b0000011;
    @(posedge clock); #1;
    memReady = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("stall_IorD", 32'(IorD), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_memRead", 32'(memRead), 32'd1);
    check("midrst_IorD", 32'(IorD), 32'd0);
    check("midrst_srcB", 32'(ALUSrcB), 32'd1);
    check("midrst_illegal", 32'(illegal), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    exp_retired = 4'd0;
    check("midrst_retired", 32'(retiredCount), 32'd0);
`endif
    #1 reset = 1'b0;
    @(posedge clock); #1;
    run_instr(0, 0, 0, -1);

    // Unsupported opcode traps and stays trapped
    enable   = 1'b1;
    memReady = 1'b1;
    opcode   = 7'b1111111;
    @(posedge clock); #1;
    @(negedge clock);
    check("decode_illegal", 32'(illegal), 32'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 20; i++) begin
      memReady = 1'($urandom_range(0, 1));
      opcode   = 7'($urandom);
      @(negedge clock);
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_memRead", 32'(memRead), 32'd0);
      check("trap_instrDone", 32'(instrDone), 32'd0);
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath mux selects and write strobes, and generates `ALUOp` for the ALU control decoder. It stalls on a shared memory ready handshake and traps on unsupported opcodes.

## Interface
Parameters:
- `COUNT_WIDTH`, 32: width of the retired-instruction counter (present only with the macro).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run enable; sampled only in FETCH.
- `opcode`  in  7  IR[6:0]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `memReady`  in  1  memory completion for the current read or write.
- `ALUOp`  out  2  00 add, 01 subtract, 10 funct-decoded.
- `ALUSrcA`  out  1  0 = PC/OldPC, 1 = rs1.
- `ALUSrcB`  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memRead`, `memWrite`  out  1 each  memory request strobes, held until `memReady`.
- `IRWrite`, `PCWrite`  out  1 each  register load strobes.
- `PCSrc`  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- `regWrite`, `memToReg`  out  1 each  register file write and its data select.
- `instrDone`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal`  out  1  sticky flag; set on an unsupported opcode.
- `retiredCount`  out  COUNT_WIDTH  instructions retired (macro only).

## Operation
- Moore FSM. All outputs decode from the current state, except `PCWrite`/`IRWrite` in FETCH, which are qualified by `memReady`, and `PCWrite` in BRANCH, which is qualified by `zero`. Any output not listed for a state is 0, and `ALUOp` defaults to 00.
- FETCH: `memRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01.
  - With `memReady`=1, assert `IRWrite` and `PCWrite`, then go to DECODE. Otherwise stay.
  - With `enable`=0, all outputs are 0 and the FSM stays in FETCH.
- DECODE: `ALUSrcA`=0 (OldPC), `ALUSrcB`=10 to precompute the branch target. Dispatch on opcode:
  - 0110011 goes to EXEC_R.
  - 0000011 and 0100011 go to MEM_ADDR.
  - 1100011 goes to BRANCH.
  - Anything else goes to TRAP.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next state is ALU_WB.
- ALU_WB: `regWrite`=1, `memToReg`=0, `instrDone`=1. Next state is FETCH.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next state is MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: `memRead`=1, `IorD`=1. Wait for `memReady`, then go to MEM_WB.
- MEM_WB: `regWrite`=1, `memToReg`=1, `instrDone`=1. Next state is FETCH.
- MEM_WRITE: `memWrite`=1, `IorD`=1. Wait for `memReady`; `instrDone`=1 in the cycle `memReady` is seen. Next state is FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCSrc`=1, `PCWrite`=`zero`, `instrDone`=1. Next state is FETCH.
- TRAP: all strobes 0. `illegal` is set on entry and stays set. TRAP is absorbing until reset.
- The opcode is only used in DECODE and MEM_ADDR. The IR is stable in between because `IRWrite` is asserted only in FETCH.

## Timing
- Reset (async, any state, mid-wait included):
  - state goes to FETCH, `illegal`=0, `retiredCount`=0.
  - outputs take the FETCH decode immediately.
  - a memory request pending at reset is abandoned; the memory side must tolerate the dropped strobe.
- Cycles per instruction with zero-wait memory (`memReady` already high):
  - R-type: 4
  - load: 5
  - store: 4
  - beq: 3
- Each cycle `memReady` stays low adds one cycle in FETCH, MEM_READ or MEM_WRITE. There is no timeout.
- `memReady` is ignored outside memory-request states.
- `enable` dropping mid-instruction has no effect; the current instruction completes and the FSM then idles in FETCH.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined:
  - `retiredCount` increments by 1 on every `instrDone` pulse and wraps modulo 2^COUNT_WIDTH.
  - Reset clears it to 0.
- Not defined: the port and counter are absent, and there is no other behavioural change.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - state enum: FETCH, DECODE, EXEC_R, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, TRAP.
  - opcode constants: OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - `ALUOp` constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - `ALUSrcB` select constants.
- Sub-module `retire_counter`, instantiated only under the macro; it takes `clock`, `reset` and `instrDone`.

## Test plan
- Reset asserted mid-MEM_READ with `memReady`=0 → immediately FETCH with `memRead`=1, `illegal`=0, `retiredCount`=0.
- R-type (opcode 0110011), `memReady`=1 → states F,D,EXEC_R,ALU_WB; `ALUOp`=10 in EXEC_R; `regWrite` in cycle 4; one `instrDone`.
- Load with `memReady` low for 3 cycles in MEM_READ → 8 cycles total; `memToReg`=1 with `regWrite` in MEM_WB.
- beq with `zero`=1, then with `zero`=0 → `PCWrite`=1 with `PCSrc`=1, then `PCWrite`=0; `ALUOp`=01 in both.
- Opcode 1111111 → TRAP after DECODE; `illegal` stays 1 for 20 cycles; no further `memRead`.
- Macro on, COUNT_WIDTH=4, 17 back-to-back stores → `retiredCount`=1 (wrap); macro off → build has no `retiredCount` port.
